// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the fetch stage.
//  - NPC_* : EX control-flow op encodings carried on redir_op
//  - fetch_state_e : IF sequencer states
//  - RESET_PC_DEF : default first fetch address
//  - npc_take() : decides whether an EX op redirects the fetch stream
package pipe_pkg;

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_ABS = 2'd2;
  localparam logic [1:0] NPC_REL = 2'd3;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // RUN  : fetch in flight or issuable
  // WAIT : slot full and stalled, no request
  // DROP : wrong-path fetch still outstanding
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  function automatic logic npc_take(input logic [1:0] op, input logic br);
    return (op == NPC_ABS) | (op == NPC_REL) | ((op == NPC_BR) & br);
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-memory request/ack bus.
// Handshake: req is held high by the master until ack; addr is stable while
// req=1 and ack=0. ack (with rdata) is only meaningful while req=1 and
// completes the transfer in the cycle it is seen high.
//  master (fetch side) : drives req, addr; receives ack, rdata
//  slave  (memory side): receives req, addr; drives ack, rdata
interface fetch_pc_ctrl_if #(
  parameter int DATA_W = 32
) ();
  logic              req;
  logic [DATA_W-1:0] addr;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_pc_ctrl_npc.sv
// Combinational next-PC unit.
//  pc_i, offset_i, br_i, op_i -> npc_o (target or pc+4), pc4_o (pc+4).
//  op ABS: npc = offset; op REL / taken BR: npc = pc + offset (wraps mod 2^W);
//  SEQ or not-taken BR: npc = pc + 4.
module fetch_pc_ctrl_npc
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] offset_i,
  input  logic              br_i,
  input  logic [1:0]        op_i,
  output logic [DATA_W-1:0] npc_o,
  output logic [DATA_W-1:0] pc4_o
);

  always_comb begin
    pc4_o = pc_i + DATA_W'(4);
    npc_o = pc4_o;
    case (op_i)
      NPC_ABS: npc_o = offset_i;
      NPC_REL: npc_o = pc_i + offset_i;
      NPC_BR:  npc_o = br_i ? (pc_i + offset_i) : pc4_o;
      default: npc_o = pc4_o;
    endcase
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// IF-stage sequencer: owns the PC, issues instruction-memory fetches and
// fills a one-entry IF/ID slot; honours ID stall and EX redirects.
// Ports:
//  clk, rst                  clock, synchronous active-high reset
//  stall                     ID cannot accept; slot holds
//  redir_op/br/pc/offset     EX control-flow information
//  imem (master)             instruction-memory req/addr/ack/rdata
//  if_valid/pc/pc4/inst      IF/ID slot contents
//  dbg_state                 current sequencer state
module fetch_pc_ctrl
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [1:0]        redir_op,
  input  logic              redir_br,
  input  logic [DATA_W-1:0] redir_pc,
  input  logic [DATA_W-1:0] redir_offset,
  fetch_pc_ctrl_if.master   imem,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_pc4,
  output logic [DATA_W-1:0] if_inst,
  output fetch_state_e      dbg_state
);

  fetch_state_e      state_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] req_addr_q;
  logic              imem_req_q;
  logic              if_valid_q;
  logic [DATA_W-1:0] if_pc_q;
  logic [DATA_W-1:0] if_pc4_q;
  logic [DATA_W-1:0] if_inst_q;

  logic              take;
  logic              ack_v;
  logic [DATA_W-1:0] unit_pc;
  logic [DATA_W-1:0] npc_d;
  logic [DATA_W-1:0] pc4_d;

  assign take  = npc_take(redir_op, redir_br);
  // An ack with no request in flight is meaningless and dropped.
  assign ack_v = imem.ack & imem_req_q;

  // One adder pair serves both jobs: on a redirect it computes the target
  // from the EX PC; otherwise op is SEQ/not-taken so it yields req_addr+4.
  assign unit_pc = take ? redir_pc : req_addr_q;

  fetch_pc_ctrl_npc #(.DATA_W(DATA_W)) u_npc (
    .pc_i     (unit_pc),
    .offset_i (redir_offset),
    .br_i     (redir_br),
    .op_i     (redir_op),
    .npc_o    (npc_d),
    .pc4_o    (pc4_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      imem_req_q <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_pc4_q   <= '0;
      if_inst_q  <= '0;
    end else if (take) begin
      if_valid_q <= 1'b0;
      pc_q       <= npc_d;
      if (imem_req_q && !imem.ack) begin
        // Wrong-path fetch still in flight: keep its address until it acks.
        state_q    <= DROP;
        imem_req_q <= 1'b1;
      end else begin
        state_q    <= RUN;
        req_addr_q <= npc_d;
        imem_req_q <= 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (if_valid_q && stall) begin
            // Slot full: withdraw the request, refetch req_addr later.
            state_q    <= WAIT;
            imem_req_q <= 1'b0;
          end else begin
            imem_req_q <= 1'b1;
            if (ack_v) begin
              if_valid_q <= 1'b1;
              if_inst_q  <= imem.rdata;
              if_pc_q    <= req_addr_q;
              if_pc4_q   <= pc4_d;
              pc_q       <= npc_d;
              req_addr_q <= npc_d;
            end else begin
              // Slot was empty or ID just consumed it.
              if_valid_q <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (!stall) begin
            // ID takes the held instruction on this edge.
            state_q    <= RUN;
            imem_req_q <= 1'b1;
            if_valid_q <= 1'b0;
          end
        end
        DROP: begin
          if (ack_v) begin
            state_q    <= RUN;
            req_addr_q <= pc_q;
          end
        end
        default: begin
          state_q    <= RUN;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem.req  = imem_req_q;
  assign imem.addr = req_addr_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_pc4    = if_pc4_q;
  assign if_inst   = if_inst_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
module tb_fetch_pc_ctrl;
  import pipe_pkg::*;

  localparam logic [31:0] K = 32'hA5A5_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        stall        = 1'b0;
  logic [1:0]  redir_op     = 2'd0;
  logic        redir_br     = 1'b0;
  logic [31:0] redir_pc     = 32'h0;
  logic [31:0] redir_offset = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;
  fetch_state_e dbg_state;

  // Memory model: rdata = addr ^ K; ack either follows req (zero wait) or
  // is driven by hand for latency tests.
  logic ack_auto = 1'b0;
  logic ack_man  = 1'b0;

  fetch_pc_ctrl_if #(.DATA_W(32)) imem_if ();
  assign imem_if.rdata = imem_if.addr ^ K;
  assign imem_if.ack   = ack_auto ? imem_if.req : ack_man;

  fetch_pc_ctrl #(.DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redir_op     (redir_op),
    .redir_br     (redir_br),
    .redir_pc     (redir_pc),
    .redir_offset (redir_offset),
    .imem         (imem_if.master),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_pc4       (if_pc4),
    .if_inst      (if_inst),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_redir(input logic [1:0] op, input logic br,
                           input logic [31:0] pc, input logic [31:0] off);
    redir_op     = op;
    redir_br     = br;
    redir_pc     = pc;
    redir_offset = off;
  endtask

  initial begin
    // ---- reset state ----
    tick(); tick();
    check_eq("rst_valid", 32'(if_valid), 32'd0);
    check_eq("rst_pc",    if_pc,   32'h0);
    check_eq("rst_pc4",   if_pc4,  32'h0);
    check_eq("rst_inst",  if_inst, 32'h0);
    check_eq("rst_req",   32'(imem_if.req), 32'd0);
    check_eq("rst_addr",  imem_if.addr, 32'h0);
    check_eq("rst_state", 32'(dbg_state), 32'(RUN));

    // ---- 1: zero-wait stream ----
    rst = 1'b0;
    ack_auto = 1'b1;
    check_eq("t1_req_c0", 32'(imem_if.req), 32'd0);
    tick();
    check_eq("t1_req_c1",  32'(imem_if.req), 32'd1);
    check_eq("t1_addr_c1", imem_if.addr, 32'h0);
    check_eq("t1_val_c1",  32'(if_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t1_valid", 32'(if_valid), 32'd1);
      check_eq("t1_pc",    if_pc,   32'(4 * i));
      check_eq("t1_pc4",   if_pc4,  32'(4 * i + 4));
      check_eq("t1_inst",  if_inst, 32'(4 * i) ^ K);
    end
    check_eq("t1_addr_end", imem_if.addr, 32'h10);

    // ---- 2: stall with slot full ----
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t2_req",   32'(imem_if.req), 32'd0);
      check_eq("t2_valid", 32'(if_valid), 32'd1);
      check_eq("t2_pc",    if_pc,   32'hC);
      check_eq("t2_inst",  if_inst, 32'hC ^ K);
      check_eq("t2_state", 32'(dbg_state), 32'(WAIT));
    end
    stall = 1'b0;
    tick();
    check_eq("t2_req_rel",  32'(imem_if.req), 32'd1);
    check_eq("t2_addr_rel", imem_if.addr, 32'h10);
    tick();
    check_eq("t2_pc_next",   if_pc,   32'h10);
    check_eq("t2_inst_next", if_inst, 32'h10 ^ K);

    // ---- 3: taken branch, nothing outstanding (wrapping add) ----
    stall = 1'b1;
    tick();
    check_eq("t3_state_wait", 32'(dbg_state), 32'(WAIT));
    set_redir(NPC_BR, 1'b1, 32'h20, 32'hFFFF_FFF0);
    tick();
    set_redir(NPC_SEQ, 1'b0, 32'h0, 32'h0);
    stall = 1'b0;
    check_eq("t3_valid", 32'(if_valid), 32'd0);
    check_eq("t3_req",   32'(imem_if.req), 32'd1);
    check_eq("t3_addr",  imem_if.addr, 32'h10);
    tick();
    check_eq("t3_pc",    if_pc,   32'h10);
    check_eq("t3_inst",  if_inst, 32'h10 ^ K);

    // ---- 4: absolute jump during a slow fetch ----
    ack_auto = 1'b0;
    ack_man  = 1'b0;
    tick();
    check_eq("t4_addr_w1",  imem_if.addr, 32'h14);
    check_eq("t4_valid_w1", 32'(if_valid), 32'd0);
    set_redir(NPC_ABS, 1'b0, 32'h0, 32'h400);
    tick();
    set_redir(NPC_SEQ, 1'b0, 32'h0, 32'h0);
    check_eq("t4_state_drop", 32'(dbg_state), 32'(DROP));
    check_eq("t4_addr_w2",    imem_if.addr, 32'h14);
    check_eq("t4_req_w2",     32'(imem_if.req), 32'd1);
    tick();
    check_eq("t4_addr_w3",    imem_if.addr, 32'h14);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    check_eq("t4_addr_tgt",  imem_if.addr, 32'h400);
    check_eq("t4_valid_drop", 32'(if_valid), 32'd0);
    check_eq("t4_state_run", 32'(dbg_state), 32'(RUN));
    ack_man = 1'b1;
    tick();
    check_eq("t4_valid", 32'(if_valid), 32'd1);
    check_eq("t4_pc",    if_pc,   32'h400);
    check_eq("t4_inst",  if_inst, 32'h400 ^ K);

    // ---- 5: relative jump in the ack cycle ----
    set_redir(NPC_REL, 1'b0, 32'h100, 32'h8);
    tick();
    set_redir(NPC_SEQ, 1'b0, 32'h0, 32'h0);
    check_eq("t5_valid", 32'(if_valid), 32'd0);
    check_eq("t5_addr",  imem_if.addr, 32'h108);
    tick();
    check_eq("t5_pc",    if_pc,   32'h108);
    check_eq("t5_pc4",   if_pc4,  32'h10C);
    check_eq("t5_inst",  if_inst, 32'h108 ^ K);

    // ---- 6: non-taken ops, then reset mid-wait ----
    set_redir(NPC_BR, 1'b0, 32'h500, 32'h40);
    tick();
    check_eq("t6_br0_pc",   if_pc,        32'h10C);
    check_eq("t6_br0_addr", imem_if.addr, 32'h110);
    set_redir(NPC_SEQ, 1'b1, 32'h700, 32'h80);
    tick();
    check_eq("t6_seq_pc",   if_pc,        32'h110);
    check_eq("t6_seq_addr", imem_if.addr, 32'h114);
    set_redir(NPC_SEQ, 1'b0, 32'h0, 32'h0);
    ack_man = 1'b0;
    tick();
    check_eq("t6_wait_req", 32'(imem_if.req), 32'd1);
    rst = 1'b1;
    tick();
    check_eq("t6_rst_valid", 32'(if_valid), 32'd0);
    check_eq("t6_rst_req",   32'(imem_if.req), 32'd0);
    check_eq("t6_rst_addr",  imem_if.addr, 32'h0);
    check_eq("t6_rst_pc",    if_pc, 32'h0);
    rst = 1'b0;
    ack_man = 1'b1;  // arrives while req=0, must be ignored
    tick();
    check_eq("t6_reissue_req",   32'(imem_if.req), 32'd1);
    check_eq("t6_reissue_addr",  imem_if.addr, 32'h0);
    check_eq("t6_reissue_valid", 32'(if_valid), 32'd0);
    tick();
    check_eq("t6_first_pc",   if_pc,   32'h0);
    check_eq("t6_first_inst", if_inst, K);
    check_eq("t6_first_val",  32'(if_valid), 32'd1);
    ack_man = 1'b0;

    // ---- report ----
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Safety net against an unexpected hang.
  initial begin
    #100000;
    $display("FAIL timeout: got no end expected end of stimulus");
    $fatal(1);
  end

endmodule
